// File: rtl/dev_reshuffler_pkg.sv
// rtl/dev_reshuffler_pkg.sv - mode encoding and element-permutation index helper for the reshuffler
package dev_reshuffler_pkg;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_ROWREV    = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    // Flat source element index feeding output element (i,j) of an n x n matrix.
    // The reserved mode falls through to passthrough.
    function automatic int permute_src(input int i, input int j, input int n, input mode_e mode);
        case (mode)
            MODE_TRANSPOSE: return j * n + i;
            MODE_ROWREV:    return i * n + (n - 1 - j);
            default:        return i * n + j;
        endcase
    endfunction

endpackage

// File: rtl/dev_reshuffler_fifo.sv
// rtl/dev_reshuffler_fifo.sv - synchronous FIFO with flush, registered ready and occupancy count
module dev_reshuffler_fifo #(
    parameter int Width = 128,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [Width-1:0]           push_data_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    output logic [Width-1:0]           pop_data_o,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    logic [Width-1:0] mem_d [Depth];
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_d, wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_d, rd_ptr_q;
    logic [CntW-1:0]  count_d, count_q;
    logic             push, pop;

    // Ready and valid depend only on stored state and the flush input.
    assign push_ready_o = (count_q != CntFull) && !clear_i;
    assign pop_valid_o  = (count_q != '0) && !clear_i;
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign count_o      = count_q;

    assign push = push_valid_i && push_ready_o;
    assign pop  = pop_valid_o && pop_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_d = count_q + CntOne;
            end else if (pop && !push) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dev_reshuffler_buffered.sv
// rtl/dev_reshuffler_buffered.sv - per-beat matrix permutation in front of an elastic FIFO
module dev_reshuffler_buffered
    import dev_reshuffler_pkg::*;
#(
    parameter int SpatPar   = 8,
    parameter int DataWidth = 64,
    parameter int Elems     = DataWidth / SpatPar,
    parameter int Depth     = 4,
    parameter int CntWidth  = $clog2(Depth + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [SpatPar*DataWidth-1:0]   a_i,
    input  logic                           a_valid_i,
    output logic                           a_ready_o,
    input  logic [1:0]                     csr_mode_i,
    input  logic                           csr_clear_i,
    output logic [SpatPar*DataWidth-1:0]   z_o,
    output logic                           z_valid_o,
    input  logic                           z_ready_i,
    output logic [CntWidth-1:0]            occupancy_o
);
    localparam int W = SpatPar * DataWidth;

    logic [W-1:0] permuted;

    always_comb begin
        permuted = '0;
        for (int i = 0; i < SpatPar; i++) begin
            for (int j = 0; j < SpatPar; j++) begin
                permuted[(i*SpatPar+j)*Elems +: Elems] =
                    a_i[permute_src(i, j, SpatPar, mode_e'(csr_mode_i))*Elems +: Elems];
            end
        end
    end

    dev_reshuffler_fifo #(
        .Width (W),
        .Depth (Depth)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (csr_clear_i),
        .push_data_i  (permuted),
        .push_valid_i (a_valid_i),
        .push_ready_o (a_ready_o),
        .pop_data_o   (z_o),
        .pop_valid_o  (z_valid_o),
        .pop_ready_i  (z_ready_i),
        .count_o      (occupancy_o)
    );

endmodule

// File: tb/tb_dev_reshuffler_buffered.sv
// tb/tb_dev_reshuffler_buffered.sv - self-checking bench for dev_reshuffler_buffered
module tb_dev_reshuffler_buffered;
    localparam int S = 2;
    localparam int DW = 16;
    localparam int E = DW / S;
    localparam int D = 4;
    localparam int W = S * DW;
    localparam int CW = $clog2(D + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [W-1:0]  a_i;
    logic          a_valid_i;
    logic          a_ready_o;
    logic [1:0]    csr_mode_i;
    logic          csr_clear_i;
    logic [W-1:0]  z_o;
    logic          z_valid_o;
    logic          z_ready_i;
    logic [CW-1:0] occupancy_o;

    int n_pass = 0;
    int n_total = 0;

    dev_reshuffler_buffered #(.SpatPar(S), .DataWidth(DW), .Depth(D)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .a_i         (a_i),
        .a_valid_i   (a_valid_i),
        .a_ready_o   (a_ready_o),
        .csr_mode_i  (csr_mode_i),
        .csr_clear_i (csr_clear_i),
        .z_o         (z_o),
        .z_valid_o   (z_valid_o),
        .z_ready_i   (z_ready_i),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Matrix view of a word: read element (i,j), build the result element by element.
    function automatic logic [W-1:0] ref_perm(input logic [W-1:0] a, input logic [1:0] mode);
        logic [E-1:0] m [S][S];
        logic [W-1:0] z;
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++)
                m[i][j] = a[(i*S+j)*E +: E];
        z = '0;
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                if (mode == 2'd1)      z[(i*S+j)*E +: E] = m[j][i];
                else if (mode == 2'd2) z[(i*S+j)*E +: E] = m[i][S-1-j];
                else                   z[(i*S+j)*E +: E] = m[i][j];
            end
        return z;
    endfunction

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] z;
    } vec_t;

    vec_t vecs [6];
    logic [W-1:0] q [$];
    logic [W-1:0] words [5];

    task automatic idle();
        a_valid_i   = 1'b0;
        csr_clear_i = 1'b0;
        csr_mode_i  = 2'd0;
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'h44332211, 32'h44332211};
        vecs[1] = '{2'd1, 32'h44332211, 32'h44223311};
        vecs[2] = '{2'd2, 32'h44332211, 32'h33441122};
        vecs[3] = '{2'd3, 32'h44332211, 32'h44332211};
        vecs[4] = '{2'd1, 32'hDDCCBBAA, 32'hDDBBCCAA};
        vecs[5] = '{2'd2, 32'hDDCCBBAA, 32'hCCDDAABB};

        rst_ni = 1'b0; a_i = '0; z_ready_i = 1'b1;
        idle();
        #1;
        check("reset a_ready", a_ready_o, 1);
        check("reset z_valid", z_valid_o, 0);
        check("reset occupancy", occupancy_o, 0);
        @(negedge clk_i); rst_ni = 1'b1;

        // Single beats from empty: no bypass, visible exactly one cycle later.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            a_valid_i = 1'b1; csr_mode_i = vecs[k].mode; a_i = vecs[k].a;
            #1;
            check("vec no bypass", z_valid_o, 0);
            check("vec a_ready", a_ready_o, 1);
            @(negedge clk_i);
            idle(); csr_mode_i = 2'd2;
            #1;
            check("vec z_valid", z_valid_o, 1);
            check("vec z_o", z_o, vecs[k].z);
            check("vec occupancy", occupancy_o, 1);
            @(negedge clk_i); #1;
            check("vec drained", z_valid_o, 0);
        end

        // Back-to-back modes 1,0,2 at full throughput.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (k < 3) begin
                a_valid_i = 1'b1; a_i = 32'h44332211;
                csr_mode_i = (k == 0) ? 2'd1 : (k == 1) ? 2'd0 : 2'd2;
            end else idle();
            #1;
            if (k > 0) begin
                check("b2b valid", z_valid_o, 1);
                check("b2b data", z_o, (k == 1) ? 32'h44223311 : (k == 2) ? 32'h44332211 : 32'h33441122);
                check("b2b occupancy", occupancy_o, 1);
            end
        end
        @(negedge clk_i); #1;
        check("b2b drained", z_valid_o, 0);

        // Fill to full with downstream stalled; fifth beat is refused.
        z_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            words[k] = $urandom; a_valid_i = 1'b1; a_i = words[k];
            #1;
            check("fill a_ready", a_ready_o, (k < 4) ? 1 : 0);
        end
        @(negedge clk_i); idle(); #1;
        check("full occupancy", occupancy_o, 4);
        check("full a_ready", a_ready_o, 0);
        z_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain valid", z_valid_o, 1);
            check("drain data", z_o, words[k]);
            check("drain occupancy", occupancy_o, 4 - k);
            @(negedge clk_i);
        end
        #1;
        check("drain empty", z_valid_o, 0);
        check("drain occupancy end", occupancy_o, 0);

        // Flush at occupancy 2 with a beat offered.
        z_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i); a_valid_i = 1'b1; a_i = $urandom;
        end
        @(negedge clk_i);
        csr_clear_i = 1'b1; a_i = 32'hCAFEF00D;
        #1;
        check("clear occupancy before", occupancy_o, 2);
        check("clear a_ready", a_ready_o, 0);
        check("clear z_valid", z_valid_o, 0);
        @(negedge clk_i); idle(); #1;
        check("clear occupancy after", occupancy_o, 0);
        check("clear z_valid after", z_valid_o, 0);
        check("clear a_ready after", a_ready_o, 1);

        // Asynchronous reset with three beats held.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); a_valid_i = 1'b1; a_i = $urandom;
        end
        @(negedge clk_i); idle(); #1;
        check("pre-reset occupancy", occupancy_o, 3);
        #2; rst_ni = 1'b0; #1;
        check("async reset occupancy", occupancy_o, 0);
        check("async reset z_valid", z_valid_o, 0);
        check("async reset a_ready", a_ready_o, 1);
        @(negedge clk_i); rst_ni = 1'b1;

        // Randomized traffic against a queue model.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            logic push, pop;
            @(negedge clk_i);
            a_valid_i   = ($urandom_range(0, 3) != 0);
            z_ready_i   = ($urandom_range(0, 2) != 0);
            csr_clear_i = ($urandom_range(0, 39) == 0);
            csr_mode_i  = 2'($urandom_range(0, 3));
            a_i         = $urandom;
            #1;
            check("rnd a_ready", a_ready_o, (q.size() < D) && !csr_clear_i);
            check("rnd z_valid", z_valid_o, (q.size() != 0) && !csr_clear_i);
            check("rnd occupancy", occupancy_o, q.size());
            if (q.size() != 0 && !csr_clear_i) check("rnd z_o", z_o, q[0]);
            push = a_valid_i && !csr_clear_i && (q.size() < D);
            pop  = z_ready_i && !csr_clear_i && (q.size() != 0);
            if (csr_clear_i) q.delete();
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ref_perm(a_i, csr_mode_i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dev_reshuffler_buffered.md
# dev_reshuffler_buffered

Parametrised streaming data reshuffler for the SNAX dev datapath. Each accepted beat is viewed as a SpatPar x SpatPar matrix of Elems-bit elements and is permuted by a per-beat mode: passthrough, transpose, or row-reverse. Results go into an internal FIFO of configurable depth, so short downstream stalls do not back-pressure the producer. The block sits between a streamer read port and an accelerator input port.

## Interface
- SpatPar, 8, matrix dimension (rows = columns), >= 2
- DataWidth, 64, bits per row; must be divisible by SpatPar
- Elems, DataWidth/SpatPar, element width in bits (derived; do not override)
- Depth, 4, FIFO entries; power of two, >= 2
- CntWidth, $clog2(Depth+1), occupancy counter width (derived)
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- a_i  input  SpatPar*DataWidth  input beat; element (i,j) is at bits [(i*SpatPar+j)*Elems +: Elems]
- a_valid_i  input  1  input valid
- a_ready_o  output  1  input ready
- csr_mode_i  input  2  permutation mode, sampled with each accepted beat
- csr_clear_i  input  1  synchronous FIFO flush
- z_o  output  SpatPar*DataWidth  FIFO head data
- z_valid_o  output  1  FIFO non-empty
- z_ready_i  input  1  downstream ready
- occupancy_o  output  CntWidth  entries currently held

## Operation
- Modes (csr_mode_i): 0 PASS z(i,j)=a(i,j); 1 TRANSPOSE z(i,j)=a(j,i); 2 ROWREV z(i,j)=a(i,SpatPar-1-j); 3 reserved, behaves as PASS.
- Permutation is combinational on a_i. The permuted word is written to the FIFO tail on push = a_valid_i && a_ready_o.
- Mode is captured per beat. Changing csr_mode_i between beats affects only later pushes, never stored entries.
- pop = z_valid_o && z_ready_i advances the head.
- a_ready_o = (occupancy < Depth) && !csr_clear_i. It is registered-state only: no combinational path from z_ready_i.
- z_valid_o = (occupancy != 0). z_o = memory[rd_ptr], valid only while z_valid_o is 1.
- Pointers are log2(Depth) bits and wrap naturally. Occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- csr_clear_i: next cycle rd_ptr = wr_ptr = 0 and occupancy = 0. While asserted, a_ready_o and z_valid_o are both 0, so no push or pop happens in that cycle. Clear has priority over everything.
- FIFO storage is not reset. Only pointers and counter are reset.

## Timing
- Reset values: a_ready_o=1, z_valid_o=0, occupancy_o=0. z_o is undefined until the first push.
- Latency: a beat pushed in cycle N is on z_o with z_valid_o=1 in cycle N+1 when the FIFO was empty.
- Throughput: one beat per cycle sustained while z_ready_i=1.
- Full (occupancy=Depth): a_ready_o=0. A pop in that cycle raises a_ready_o in the next cycle (one bubble at full is accepted).
- Empty with a push and no valid head: no bypass. Pop is impossible, and occupancy becomes 1 next cycle.
- Push and pop in the same cycle at occupancy=1: the head advances to the new entry, and occupancy stays 1.
- z_valid_o and z_o stay stable while z_valid_o && !z_ready_i.
- Reset asserted mid-operation: everything returns to the reset values immediately (asynchronously), and stored beats are lost.

## Structure
- Package dev_reshuffler_pkg holds:
  - the mode_e enum (MODE_PASS=0, MODE_TRANSPOSE=1, MODE_ROWREV=2, MODE_RSVD=3);
  - the function permute(a, mode), parametrised via the module's generate loops if package parametrisation is not available.
- One sub-module, dev_reshuffler_fifo (parameters Width, Depth):
  - ports clk_i, rst_ni, clear_i, push/pop handshake, data, count;
  - the top holds the permutation and glue only.

## Test plan
All scenarios use SpatPar=2, DataWidth=16 (Elems=8), Depth=4. Elements of a_i=0x44332211 are a(0,0)=11, a(0,1)=22, a(1,0)=33, a(1,1)=44.
- Mode 0, push 0x44332211 with z_ready_i=1 -> z_o=0x44332211 with z_valid_o=1 exactly one cycle later.
- Mode 1, same word -> z_o=0x44223311. Mode 2, same word -> z_o=0x33441122.
- Back-to-back beats with modes 1,0,2 and z_ready_i=1 -> outputs 0x44223311, 0x44332211, 0x33441122 in order, one per cycle.
- Hold z_ready_i=0, push 5 beats -> after 4 beats a_ready_o=0 and occupancy_o=4. Release z_ready_i -> 4 beats drain in order, with no loss or duplication.
- FIFO at occupancy=2, pulse csr_clear_i while a_valid_i=1 -> that beat is not accepted, and next cycle occupancy_o=0 and z_valid_o=0.
- Assert rst_ni=0 asynchronously with occupancy=3 -> immediately occupancy_o=0, z_valid_o=0, a_ready_o=1.
